alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE, default 4, legal range 1..255: number of clock cycles the ALU inputs are held stable before the result is captured.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  64  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3  ALU control code: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 PASS_A.
REQ-008 SHALL have ports alu_a, alu_b  output  64 and alu_cntrl  output  3  registered drive to the shared ALU.
REQ-009 SHALL have ports alu_result  input  64 and alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1  ALU outputs.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_id  output  1  requester index of the response.
REQ-012 SHALL have ports rsp_result  output  64 and rsp_flags  output  4  {negative, zero, overflow, carry_out}.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, ready SHALL be driven combinationally: only the granted requester sees ready=1, and only if its valid=1; in WAIT and RESP both ready outputs SHALL be 0.
REQ-016 Grant: if a single valid is asserted, that requester wins; if both are asserted, the requester not granted last wins (round-robin).
REQ-017 The round-robin pointer SHALL update only on a handshake (valid and ready both high).
REQ-018 On a handshake, alu_a, alu_b and alu_cntrl SHALL load the winner's a, b and op, the requester index SHALL be stored, the settle counter SHALL load SETTLE-1, and the FSM SHALL go to WAIT.
REQ-019 alu_a, alu_b and alu_cntrl SHALL hold their values until the next handshake; later changes on the req_* inputs SHALL have no effect.
REQ-020 In WAIT, the counter SHALL decrement each cycle.
REQ-021 When the counter is 0 in WAIT, the clock edge SHALL capture alu_result and the four flags into rsp_result and rsp_flags, and the FSM SHALL go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 for exactly one cycle, rsp_id SHALL equal the stored index, and the FSM SHALL go to IDLE.
REQ-023 Latency: handshake at edge t gives rsp_valid high during the cycle after edge t+SETTLE; issue interval is at least SETTLE+2 cycles.
REQ-024 rsp_result, rsp_flags and rsp_id SHALL hold their values after RESP until the next capture.
REQ-025 op 001 SHALL be accepted and forwarded unchanged; no op code SHALL be rejected.
REQ-026 No combinational path SHALL exist from the alu_* inputs to any output.

Reset
REQ-027 Asserting reset_n=0 SHALL, immediately and independent of clk, force state to IDLE, all registered outputs to 0 (alu_cntrl=000), the counter to 0 and the pointer to "last=1" so that req0 wins the first tie.
REQ-028 Reset during WAIT or RESP SHALL drop the in-flight operation; no rsp_valid SHALL be produced for it.
REQ-029 The first handshake after reset_n rises SHALL proceed normally with no extra delay.

Verification
REQ-030 SETTLE=4, req0 ADD a=5 b=7 -> req0_ready=1 in the same cycle; rsp_valid exactly 5 cycles after the handshake edge; rsp_result=12, rsp_id=0, rsp_flags=0000.
REQ-031 After reset, req0 SUB a=3 b=3 and req1 XOR a=0xF0 b=0xFF both valid -> req0 served first (result 0, flags 0101), then req1 (result 0x0F, rsp_id=1); both valid again -> req0 wins.
REQ-032 req1 ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> rsp_result=0x8000_0000_0000_0000, rsp_flags=1010.
REQ-033 reset_n pulsed low 2 cycles into WAIT -> busy=0 and all outputs 0 at once; no rsp_valid; next req0 PASS_A a=9 returns 9.
REQ-034 req1 valid held while busy, with req1_a changed mid-WAIT -> req1_ready stays 0 until IDLE; alu_a unchanged during WAIT.
REQ-035 SETTLE=1, req0 AND a=0xC b=0xA -> rsp_valid 2 cycles after the handshake edge, result 0x8; back-to-back requests are accepted every 3 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared multi-cycle ALU
// Operands are held on the registered ALU drive for SETTLE cycles, then the result is captured.
module alu_arbiter #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [63:0] alu_a_q, alu_a_d;
    logic [63:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_cntrl_q, alu_cntrl_d;
    logic [63:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_id_q, rsp_id_d;
    logic        grant;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cntrl_d  = alu_cntrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_id_d     = rsp_id_q;
        grant        = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0_valid && req1_valid) begin
                    grant = ~last_q;
                end else begin
                    grant = req1_valid;
                end
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                if (req0_ready || req1_ready) begin
                    alu_a_d     = grant ? req1_a  : req0_a;
                    alu_b_d     = grant ? req1_b  : req0_b;
                    alu_cntrl_d = grant ? req1_op : req0_op;
                    id_d        = grant;
                    last_d      = grant;
                    cnt_d       = 8'(SETTLE - 1);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
                    rsp_id_d     = id_q;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= 64'd0;
            alu_b_q      <= 64'd0;
            alu_cntrl_q  <= 3'b000;
            rsp_result_q <= 64'd0;
            rsp_flags_q  <= 4'd0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cntrl_q  <= alu_cntrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cntrl  = alu_cntrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (SETTLE=4 and SETTLE=1 instances)
module tb_alu_arbiter;
    localparam int S4 = 4;
    localparam int S1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;

    logic        d4_r0rdy, d4_r1rdy, d4_n, d4_z, d4_v, d4_c, d4_rv, d4_rid, d4_busy;
    logic [63:0] d4_alu_a, d4_alu_b, d4_res, d4_rres;
    logic [2:0]  d4_cntrl;
    logic [3:0]  d4_rfl;
    logic        d1_r0rdy, d1_r1rdy, d1_n, d1_z, d1_v, d1_c, d1_rv, d1_rid, d1_busy;
    logic [63:0] d1_alu_a, d1_alu_b, d1_res, d1_rres;
    logic [2:0]  d1_cntrl;
    logic [3:0]  d1_rfl;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural shared ALU: returns {negative, zero, overflow, carry_out, result}.
    function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        logic [64:0] s;
        logic [63:0] r;
        logic        v, c;
        v = 1'b0; c = 1'b0; s = '0;
        case (op)
            3'b010: begin
                s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1; r = s[63:0]; c = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100:  r = a & b;
            3'b101:  r = a | b;
            3'b110:  r = a ^ b;
            3'b111:  r = a;
            default: r = b;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    assign {d4_n, d4_z, d4_v, d4_c, d4_res} = alu_fn(d4_alu_a, d4_alu_b, d4_cntrl);
    assign {d1_n, d1_z, d1_v, d1_c, d1_res} = alu_fn(d1_alu_a, d1_alu_b, d1_cntrl);

    alu_arbiter #(.SETTLE(S4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(d4_r0rdy), .req1_ready(d4_r1rdy),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_cntrl(d4_cntrl),
        .alu_result(d4_res), .alu_negative(d4_n), .alu_zero(d4_z),
        .alu_overflow(d4_v), .alu_carry_out(d4_c),
        .rsp_valid(d4_rv), .rsp_id(d4_rid), .rsp_result(d4_rres), .rsp_flags(d4_rfl),
        .busy(d4_busy)
    );

    alu_arbiter #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(d1_r0rdy), .req1_ready(d1_r1rdy),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_cntrl(d1_cntrl),
        .alu_result(d1_res), .alu_negative(d1_n), .alu_zero(d1_z),
        .alu_overflow(d1_v), .alu_carry_out(d1_c),
        .rsp_valid(d1_rv), .rsp_id(d1_rid), .rsp_result(d1_rres), .rsp_flags(d1_rfl),
        .busy(d1_busy)
    );

    task automatic set_req(input bit id, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for a ready; returns just after the handshake edge.
    task automatic handshake(input bit s1, output bit got, output bit id, output bit both, output int waits);
        logic r0, r1;
        got = 1'b0; id = 1'b0; both = 1'b0; waits = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            r0 = s1 ? d1_r0rdy : d4_r0rdy;
            r1 = s1 ? d1_r1rdy : d4_r1rdy;
            if (r0 || r1) begin
                got = 1'b1; id = r1; both = r0 && r1;
            end else begin
                @(negedge clk); waits++;
            end
        end
        if (got) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rsp(input bit s1, output int n, output bit seen);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); n++;
            if (s1 ? d1_rv : d4_rv) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({d4_busy, d4_r0rdy, d4_r1rdy, d4_rv, d4_rid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {d4_busy, d4_r0rdy, d4_r1rdy, d4_rv, d4_rid});
        end
        n_checks++;
        if ({d4_alu_a, d4_alu_b, d4_cntrl} !== '0) begin
            n_fail++; $display("FAIL reset_alu_drive: got a=%h b=%h op=%b expected 0", d4_alu_a, d4_alu_b, d4_cntrl);
        end
        n_checks++;
        if ({d4_rres, d4_rfl} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got res=%h flags=%b expected 0", d4_rres, d4_rfl);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_add();
        bit got, id, both, seen; int waits, n;
        set_req(0, 64'd5, 64'd7, 3'b010);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0;
        n_checks++;
        if (!(got && id == 1'b0 && !both && waits == 0)) begin
            n_fail++; $display("FAIL add_handshake: got got=%0d id=%0d both=%0d waits=%0d expected 1 0 0 0", got, id, both, waits);
        end
        n_checks++;
        if (d4_alu_a !== 64'd5 || d4_alu_b !== 64'd7 || d4_cntrl !== 3'b010 || d4_busy !== 1'b1) begin
            n_fail++; $display("FAIL add_drive: got a=%h b=%h op=%b busy=%b expected 5 7 010 1", d4_alu_a, d4_alu_b, d4_cntrl, d4_busy);
        end
        wait_rsp(0, n, seen);
        n_checks++;
        if (!seen || n != S4 + 1) begin
            n_fail++; $display("FAIL add_latency: got seen=%0d cycles=%0d expected 1 %0d", seen, n, S4 + 1);
        end
        n_checks++;
        if (d4_rres !== 64'd12 || d4_rfl !== 4'b0000 || d4_rid !== 1'b0) begin
            n_fail++; $display("FAIL add_rsp: got res=%h flags=%b id=%b expected c 0000 0", d4_rres, d4_rfl, d4_rid);
        end
        @(negedge clk);
        n_checks++;
        if (d4_rv !== 1'b0 || d4_rres !== 64'd12) begin
            n_fail++; $display("FAIL add_one_shot_hold: got rv=%b res=%h expected 0 c", d4_rv, d4_rres);
        end
    endtask

    task automatic test_tie();
        bit got, id, both, seen; int waits, n;
        do_reset();
        set_req(0, 64'd3, 64'd3, 3'b011);
        set_req(1, 64'hF0, 64'hFF, 3'b110);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0;
        n_checks++;
        if (!(got && id == 1'b0 && !both)) begin
            n_fail++; $display("FAIL tie_first: got got=%0d id=%0d both=%0d expected 1 0 0", got, id, both);
        end
        wait_rsp(0, n, seen);
        n_checks++;
        if (!seen || d4_rres !== 64'd0 || d4_rfl !== 4'b0101 || d4_rid !== 1'b0) begin
            n_fail++; $display("FAIL tie_sub_rsp: got seen=%0d res=%h flags=%b id=%b expected 1 0 0101 0", seen, d4_rres, d4_rfl, d4_rid);
        end
        handshake(0, got, id, both, waits);
        req1_valid = 1'b0;
        n_checks++;
        if (!(got && id == 1'b1)) begin
            n_fail++; $display("FAIL tie_second: got got=%0d id=%0d expected 1 1", got, id);
        end
        wait_rsp(0, n, seen);
        n_checks++;
        if (!seen || d4_rres !== 64'h0F || d4_rfl !== 4'b0000 || d4_rid !== 1'b1) begin
            n_fail++; $display("FAIL tie_xor_rsp: got seen=%0d res=%h flags=%b id=%b expected 1 f 0000 1", seen, d4_rres, d4_rfl, d4_rid);
        end
        set_req(0, 64'd1, 64'd1, 3'b010);
        set_req(1, 64'd2, 64'd2, 3'b010);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (!(got && id == 1'b0)) begin
            n_fail++; $display("FAIL tie_rr_again: got got=%0d id=%0d expected 1 0", got, id);
        end
        wait_rsp(0, n, seen);
    endtask

    task automatic test_overflow();
        bit got, id, both, seen; int waits, n;
        set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        handshake(0, got, id, both, waits);
        req1_valid = 1'b0;
        wait_rsp(0, n, seen);
        n_checks++;
        if (!got || id !== 1'b1 || !seen || d4_rres !== 64'h8000_0000_0000_0000 || d4_rfl !== 4'b1010 || d4_rid !== 1'b1) begin
            n_fail++; $display("FAIL overflow_rsp: got id=%b seen=%0d res=%h flags=%b expected 1 1 8000000000000000 1010", id, seen, d4_rres, d4_rfl);
        end
    endtask

    task automatic test_reset_in_wait();
        bit got, id, both, seen, rv_seen; int waits, n;
        set_req(0, 64'hABC, 64'd1, 3'b010);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({d4_busy, d4_rv, d4_rid, d4_cntrl, d4_rfl} !== '0 || d4_alu_a !== 64'd0 || d4_rres !== 64'd0) begin
            n_fail++; $display("FAIL reset_async: got busy=%b rv=%b a=%h res=%h flags=%b expected all 0", d4_busy, d4_rv, d4_alu_a, d4_rres, d4_rfl);
        end
        rv_seen = 1'b0;
        repeat (2) begin @(negedge clk); rv_seen |= d4_rv; end
        #1 reset_n = 1'b1;
        repeat (8) begin @(negedge clk); rv_seen |= d4_rv; end
        n_checks++;
        if (rv_seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop: got rsp_valid=%b expected 0", rv_seen);
        end
        #1;
        set_req(0, 64'd9, 64'd0, 3'b111);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0;
        wait_rsp(0, n, seen);
        n_checks++;
        if (!got || id !== 1'b0 || waits != 0 || !seen || n != S4 + 1 || d4_rres !== 64'd9) begin
            n_fail++; $display("FAIL reset_recover: got id=%b waits=%0d cycles=%0d res=%h expected 0 0 %0d 9", id, waits, n, d4_rres, S4 + 1);
        end
    endtask

    task automatic test_hold_busy();
        bit got, id, both, seen; int waits, n;
        set_req(0, 64'h1234, 64'd2, 3'b010);
        handshake(0, got, id, both, waits);
        req0_valid = 1'b0;
        set_req(1, 64'h11, 64'h5, 3'b101);
        for (int k = 0; k < 20 && d4_busy; k++) begin
            @(negedge clk); #1;
            if (d4_busy) begin
                n_checks++;
                if (d4_r1rdy !== 1'b0 || d4_alu_a !== 64'h1234) begin
                    n_fail++; $display("FAIL busy_hold: got ready1=%b alu_a=%h expected 0 1234", d4_r1rdy, d4_alu_a);
                end
                if (d4_rv && d4_rres !== 64'h1236) begin
                    n_checks++; n_fail++; $display("FAIL busy_rsp: got res=%h expected 1236", d4_rres);
                end
                if (k == 1) req1_a = 64'h22;
            end
        end
        handshake(0, got, id, both, waits);
        req1_valid = 1'b0;
        n_checks++;
        if (!got || id !== 1'b1 || waits != 0 || d4_alu_a !== 64'h22) begin
            n_fail++; $display("FAIL busy_release: got id=%b waits=%0d alu_a=%h expected 1 0 22", id, waits, d4_alu_a);
        end
        wait_rsp(0, n, seen);
        n_checks++;
        if (!seen || d4_rres !== 64'h27 || d4_rid !== 1'b1) begin
            n_fail++; $display("FAIL busy_rsp2: got seen=%0d res=%h id=%b expected 1 27 1", seen, d4_rres, d4_rid);
        end
    endtask

    task automatic test_random();
        bit got, id, both, seen, last; int waits, n;
        bit          pend[2];
        logic [63:0] pa[2], pb[2];
        logic [2:0]  pop[2];
        logic [67:0] exp;
        bit          ew;
        do_reset();
        last = 1'b1; pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1 || (r == 1 && !pend[0]))) begin
                    case ($urandom_range(0, 3))
                        0:       pa[r] = 64'h7FFF_FFFF_FFFF_FFFF;
                        1:       pa[r] = '1;
                        2:       pa[r] = 64'd0;
                        default: pa[r] = {$urandom(), $urandom()};
                    endcase
                    pb[r] = ($urandom_range(0, 2) == 0) ? 64'd1 : {$urandom(), $urandom()};
                    pop[r] = 3'($urandom_range(0, 7));
                    pend[r] = 1'b1;
                    set_req(r[0], pa[r], pb[r], pop[r]);
                end
            end
            ew = (pend[0] && pend[1]) ? ~last : pend[1];
            handshake(0, got, id, both, waits);
            n_checks++;
            if (!got || id !== ew || both) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got got=%0d id=%0d both=%0d expected 1 %0d 0", it, got, id, both, ew);
            end
            if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            pend[id] = 1'b0; last = id;
            exp = alu_fn(pa[id], pb[id], pop[id]);
            if (pend[~id] && $urandom_range(0, 1) == 1) begin
                pa[~id] = {$urandom(), $urandom()};
                if (id) req0_a = pa[0]; else req1_a = pa[1];
            end
            wait_rsp(0, n, seen);
            n_checks++;
            if (!seen || n != S4 + 1 || d4_rres !== exp[63:0] || d4_rfl !== exp[67:64] || d4_rid !== id || d4_alu_a !== pa[id]) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got cycles=%0d res=%h flags=%b id=%b expected %0d %h %b %b", it, n, d4_rres, d4_rfl, d4_rid, S4 + 1, exp[63:0], exp[67:64], id);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back_settle1();
        bit got, id, both; int waits, c_prev, first_rv;
        do_reset();
        set_req(0, 64'hC, 64'hA, 3'b100);
        handshake(1, got, id, both, waits);
        n_checks++;
        if (!got || id !== 1'b0 || waits != 0) begin
            n_fail++; $display("FAIL s1_handshake: got got=%0d id=%0d waits=%0d expected 1 0 0", got, id, waits);
        end
        c_prev = cyc; first_rv = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); #1;
            if (d1_rv) begin
                if (first_rv == 0) first_rv = k;
                n_checks++;
                if (d1_rres !== 64'h8 || d1_rid !== 1'b0) begin
                    n_fail++; $display("FAIL s1_rsp: got res=%h id=%b expected 8 0", d1_rres, d1_rid);
                end
            end
            if (d1_r0rdy) begin
                n_checks++;
                if (cyc + 1 - c_prev != S1 + 2) begin
                    n_fail++; $display("FAIL s1_interval: got %0d expected %0d", cyc + 1 - c_prev, S1 + 2);
                end
                c_prev = cyc + 1;
            end
        end
        req0_valid = 1'b0;
        n_checks++;
        if (first_rv != S1 + 1) begin
            n_fail++; $display("FAIL s1_latency: got %0d expected %0d", first_rv, S1 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_overflow();
        test_reset_in_wait();
        test_hold_busy();
        test_random();
        test_back_to_back_settle1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
